// File: rtl/port_rr_arbiter.sv
// port_rr_arbiter: 4-input round-robin arbiter feeding a single registered
// output stage. One packet per cycle when downstream keeps out_ready high.
// The accept path (in_ready) looks through out_ready so a full output
// register can be refilled on the same edge that drains it.
module port_rr_arbiter #(
    parameter int WIDTH = 20,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_src,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   pkt_count,
    output logic               busy
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr;
    logic [1:0] winner;
    logic       any_req;
    logic       open;
    logic       grant;

    // First requester in search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    // Walk from the farthest offset down so the nearest one wins.
    always_comb begin
        winner = ptr;
        for (int k = 3; k >= 0; k--) begin
            logic [1:0] idx;
            idx = ptr + 2'(k);
            if (in_valid[idx]) winner = idx;
        end
    end

    assign any_req = |in_valid;
    // The output slot can take a packet if empty or if it drains this edge.
    assign open    = (state == IDLE) || out_ready;
    // rst_n gating keeps in_ready low while reset is held.
    assign grant   = open && any_req && rst_n;

    // One-hot accept strobe for the winning port.
    always_comb begin
        in_ready = '0;
        if (grant) in_ready[winner] = 1'b1;
    end

    // Next-state: fill on grant, empty when drained with nothing to refill.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant) state_nxt = HOLD;
            HOLD: if (out_ready && !grant) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Output register and pointer load on grant; everything else holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_src  <= '0;
            ptr      <= '0;
        end else if (grant) begin
            out_data <= in_data[winner*WIDTH +: WIDTH];
            out_src  <= winner;
            ptr      <= winner + 2'd1;
        end
    end

    // Saturating count of packets handed downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pkt_count <= '0;
        else if (out_valid && out_ready && !(&pkt_count))
            pkt_count <= pkt_count + 1'b1;
    end

    assign out_valid = (state == HOLD);
    assign busy      = out_valid;

endmodule

// File: tb/tb_port_rr_arbiter.sv
// Directed bench for port_rr_arbiter. A second instance with CNT_W=4 shares
// all inputs so counter saturation can be seen in a short run.
module tb_port_rr_arbiter;
    localparam int WIDTH = 20;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic               out_ready;

    logic [3:0]       in_ready, in_ready4;
    logic             out_valid, out_valid4;
    logic [WIDTH-1:0] out_data, out_data4;
    logic [1:0]       out_src, out_src4;
    logic [15:0]      pkt_count;
    logic [3:0]       pkt_count4;
    logic             busy, busy4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    port_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .out_ready(out_ready), .pkt_count(pkt_count),
        .busy(busy)
    );

    port_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready4), .out_valid(out_valid4), .out_data(out_data4),
        .out_src(out_src4), .out_ready(out_ready), .pkt_count(pkt_count4),
        .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n     = 1'b1;
    endtask

    task automatic set_port(input int p, input logic [WIDTH-1:0] d);
        in_data[p*WIDTH +: WIDTH] = d;
    endtask

    task automatic test_reset();
        in_data   = '0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #3;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b exp 0000", in_ready); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b/%b exp 0/0", out_valid, busy); end
        checks++; if (out_data !== '0 || out_src !== 2'd0) begin errors++; $display("FAIL reset_out_regs got %h/%0d exp 0/0", out_data, out_src); end
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt_count got %0d exp 0", pkt_count); end
        tick();
        in_valid = 4'b0000;
        rst_n    = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        set_port(2, 20'h12345);
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_in_ready got %b exp 0100", in_ready); end
        tick();
        in_valid = 4'b0000;
        checks++; if (out_valid !== 1'b1 || out_data !== 20'h12345 || out_src !== 2'd2)
            begin errors++; $display("FAIL single_out got v=%b d=%h s=%0d exp v=1 d=12345 s=2", out_valid, out_data, out_src); end
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL single_cnt0 got %0d exp 0", pkt_count); end
        tick();
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL single_cnt1 got %0d exp 1", pkt_count); end
        checks++; if (out_valid !== 1'b0 || out_data !== 20'h12345 || out_src !== 2'd2)
            begin errors++; $display("FAIL single_drain got v=%b d=%h s=%0d exp v=0 d=12345 s=2", out_valid, out_data, out_src); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int p = 0; p < 4; p++) set_port(p, 20'hA0000 + 20'(p));
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_grant got %b exp 0001", in_ready); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_src !== 2'((k-1)%4) || out_data !== 20'hA0000 + 20'((k-1)%4))
                begin errors++; $display("FAIL rr_seq%0d got v=%b s=%0d d=%h exp s=%0d", k, out_valid, out_src, out_data, (k-1)%4); end
            checks++; if (pkt_count !== 16'(k-1)) begin errors++; $display("FAIL rr_cnt%0d got %0d exp %0d", k, pkt_count, k-1); end
        end
        in_valid = 4'b0000;
        tick();
        checks++; if (out_valid !== 1'b0 || pkt_count !== 16'd5) begin errors++; $display("FAIL rr_drain got v=%b c=%0d exp v=0 c=5", out_valid, pkt_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int p = 0; p < 4; p++) set_port(p, 20'hB0000 + 20'(p));
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        tick();
        in_valid = 4'b1001;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready%0d got %b exp 0000", c, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_data !== 20'hB0001 || out_src !== 2'd1 || pkt_count !== 16'd0)
                begin errors++; $display("FAIL bp_hold%0d got v=%b d=%h s=%0d c=%0d exp v=1 d=b0001 s=1 c=0", c, out_valid, out_data, out_src, pkt_count); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL bp_release got %b exp 1000", in_ready); end
        tick();
        in_valid = 4'b0000;
        checks++; if (out_src !== 2'd3 || out_data !== 20'hB0003 || pkt_count !== 16'd1)
            begin errors++; $display("FAIL bp_next got s=%0d d=%h c=%0d exp s=3 d=b0003 c=1", out_src, out_data, pkt_count); end
        tick();
        checks++; if (out_valid !== 1'b0 || pkt_count !== 16'd2) begin errors++; $display("FAIL bp_drain got v=%b c=%0d exp v=0 c=2", out_valid, pkt_count); end
    endtask

    task automatic test_saturation();
        do_reset();
        set_port(0, 20'hC0000);
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        for (int t = 1; t <= 17; t++) begin
            tick();
            checks++; if (pkt_count4 !== 4'((t-1) > 15 ? 15 : (t-1)))
                begin errors++; $display("FAIL sat_cnt4_t%0d got %0d exp %0d", t, pkt_count4, (t-1) > 15 ? 15 : (t-1)); end
        end
        in_valid = 4'b0000;
        tick();
        checks++; if (pkt_count4 !== 4'd15) begin errors++; $display("FAIL sat_cnt4_final got %0d exp 15", pkt_count4); end
        checks++; if (pkt_count !== 16'd17) begin errors++; $display("FAIL sat_cnt16_final got %0d exp 17", pkt_count); end
    endtask

    task automatic test_reset_mid_hold();
        for (int p = 0; p < 4; p++) set_port(p, 20'hD0000 + 20'(p));
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        tick();
        in_valid = 4'b0000;
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd1) begin errors++; $display("FAIL rst_hold_pre got v=%b s=%0d exp v=1 s=1", out_valid, out_src); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || pkt_count !== 16'd0 || out_data !== '0)
            begin errors++; $display("FAIL rst_hold_async got v=%b c=%0d d=%h exp v=0 c=0 d=0", out_valid, pkt_count, out_data); end
        tick();
        rst_n    = 1'b1;
        in_valid = 4'b1111;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rst_hold_ptr got %b exp 0001", in_ready); end
        in_valid = 4'b1000;
        #1;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL rst_hold_p3_ready got %b exp 1000", in_ready); end
        tick();
        in_valid = 4'b0000;
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 20'hD0003)
            begin errors++; $display("FAIL rst_hold_p3_out got v=%b s=%0d d=%h exp v=1 s=3 d=d0003", out_valid, out_src, out_data); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_saturation();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
